// File: rtl/edm_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : edm_tx_sched
// Purpose  : Unit-granular scheduler for the EDM REQ/MEM/NET TX queues.
//            Arbitrates only between units, protects NET from starvation,
//            bounds unit length with a watchdog and drives a hysteretic
//            tx_pause toward the XGMII TX path.
// Revision : 1.0  initial release
// ============================================================================
module edm_tx_sched #(
   parameter int STARVE_LIM = 4,
   parameter int PAUSE_ON   = 5,
   parameter int PAUSE_OFF  = 8,
   parameter int MAX_WORDS  = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       reqfin,
   input  logic       reqq_empty,
   input  logic       memq_empty,
   input  logic       netq_empty,
   input  logic       reqq_last,
   input  logic       memq_last,
   input  logic       netq_last,
   input  logic [3:0] netq_space,
   output logic       reqq_read,
   output logic       memq_read,
   output logic       netq_read,
   output logic [1:0] sel,
   output logic       tx_pause,
   output logic       unit_err
);

   localparam int HPW = $clog2(STARVE_LIM + 1);
   localparam int WCW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

   localparam logic [HPW-1:0] STARVE_MAX  = HPW'(STARVE_LIM);
   localparam logic [WCW-1:0] WCNT_LAST   = WCW'(MAX_WORDS - 1);
   localparam logic [4:0]     PAUSE_ON_V  = 5'(PAUSE_ON);
   localparam logic [4:0]     PAUSE_OFF_V = 5'(PAUSE_OFF);

   // State code doubles as the sel encoding.
   localparam logic [1:0] IDLE  = 2'b00;
   localparam logic [1:0] S_REQ = 2'b01;
   localparam logic [1:0] S_MEM = 2'b10;
   localparam logic [1:0] S_NET = 2'b11;

   logic [1:0]     state;
   logic [1:0]     state_next;
   logic [HPW-1:0] hp_cnt;
   logic [HPW-1:0] hp_next;
   logic [WCW-1:0] wcnt;
   logic [WCW-1:0] wcnt_next;
   logic           cur_read;
   logic           cur_last;
   logic           unit_end;
   logic           wdog_end;

   // State register; reset abandons any unit in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Outputs: pop the active queue whenever it has data, else emit idle fill.
   always_comb begin
      reqq_read = (state == S_REQ) && !reqq_empty;
      memq_read = (state == S_MEM) && !memq_empty;
      netq_read = (state == S_NET) && !netq_empty;
      sel       = (reqq_read || memq_read || netq_read) ? state : IDLE;
   end

   // Unit boundary detection: last flag of the active queue or watchdog limit.
   always_comb begin
      cur_read = reqq_read || memq_read || netq_read;
      case (state)
         S_REQ:   cur_last = reqq_last;
         S_MEM:   cur_last = memq_last;
         S_NET:   cur_last = netq_last;
         default: cur_last = 1'b0;
      endcase
      unit_end  = cur_read && (cur_last || (wcnt == WCNT_LAST));
      wdog_end  = unit_end && !cur_last;
      wcnt_next = unit_end ? '0 : (cur_read ? wcnt + WCW'(1) : wcnt);
   end

   // Starvation counter update; a clear always beats an increment.
   always_comb begin
      hp_next = hp_cnt;
      if (netq_empty || (unit_end && (state == S_NET))) begin
         hp_next = '0;
      end else if (unit_end && ((state == S_REQ) || (state == S_MEM)) &&
                   (hp_cnt < STARVE_MAX)) begin
         hp_next = hp_cnt + HPW'(1);
      end
   end

   // Next-state: arbitrate in IDLE or on a unit end. The post-update
   // starvation count is used so NET wins right after the limiting unit.
   always_comb begin
      state_next = state;
      if ((state == IDLE) || unit_end) begin
         if (!reqfin && !reqq_empty) begin
            state_next = S_REQ;
         end else if ((hp_next >= STARVE_MAX) && !netq_empty) begin
            state_next = S_NET;
         end else if (!memq_empty) begin
            state_next = S_MEM;
         end else if (!reqq_empty) begin
            state_next = S_REQ;
         end else if (!netq_empty) begin
            state_next = S_NET;
         end else begin
            state_next = IDLE;
         end
      end
   end

   // Counters and watchdog error pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hp_cnt   <= '0;
         wcnt     <= '0;
         unit_err <= 1'b0;
      end else begin
         hp_cnt   <= hp_next;
         wcnt     <= wcnt_next;
         unit_err <= wdog_end;
      end
   end

   // Hysteretic backpressure toward TX, independent of scheduling.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_pause <= 1'b0;
      end else if ({1'b0, netq_space} < PAUSE_ON_V) begin
         tx_pause <= 1'b1;
      end else if ({1'b0, netq_space} >= PAUSE_OFF_V) begin
         tx_pause <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_edm_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_edm_tx_sched
// Purpose  : Directed scoreboard bench for edm_tx_sched. Queue contents are
//            modelled as lists of last flags; expected per-cycle
//            {unit_err, sel} values are queued with the stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_edm_tx_sched;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       reqfin;
   logic       reqq_empty, memq_empty, netq_empty;
   logic       reqq_last, memq_last, netq_last;
   logic [3:0] netq_space;
   logic       reqq_read, memq_read, netq_read;
   logic [1:0] sel;
   logic       tx_pause;
   logic       unit_err;

   bit         req_m[$];
   bit         mem_m[$];
   bit         net_m[$];
   logic [2:0] exp_q[$];
   logic       net_hold;
   logic       exp_pause;
   int         errors = 0;
   int         checks = 0;

   edm_tx_sched #(
      .STARVE_LIM(4),
      .PAUSE_ON  (5),
      .PAUSE_OFF (8),
      .MAX_WORDS (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .reqfin     (reqfin),
      .reqq_empty (reqq_empty),
      .memq_empty (memq_empty),
      .netq_empty (netq_empty),
      .reqq_last  (reqq_last),
      .memq_last  (memq_last),
      .netq_last  (netq_last),
      .netq_space (netq_space),
      .reqq_read  (reqq_read),
      .memq_read  (memq_read),
      .netq_read  (netq_read),
      .sel        (sel),
      .tx_pause   (tx_pause),
      .unit_err   (unit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present queue head flags to the DUT.
   task automatic drive();
      reqq_empty = (req_m.size() == 0);
      memq_empty = (mem_m.size() == 0);
      netq_empty = (net_m.size() == 0) || net_hold;
      reqq_last  = (req_m.size() != 0) ? req_m[0] : 1'b0;
      memq_last  = (mem_m.size() != 0) ? mem_m[0] : 1'b0;
      netq_last  = (net_m.size() != 0) ? net_m[0] : 1'b0;
   endtask

   task automatic push(input logic [2:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   // One cycle: compare mid-cycle, then pop the queues the DUT read.
   task automatic tick();
      logic [2:0] e;
      logic [2:0] er;
      logic [2:0] rd;
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL sb_underrun: observed=empty expected=entry");
         e = 3'b000;
      end else begin
         e = exp_q.pop_front();
      end
      case (e[1:0])
         2'b01:   er = 3'b100;
         2'b10:   er = 3'b010;
         2'b11:   er = 3'b001;
         default: er = 3'b000;
      endcase
      chk("sel", {6'd0, sel}, {6'd0, e[1:0]});
      chk("reads", {5'd0, reqq_read, memq_read, netq_read}, {5'd0, er});
      chk("unit_err", {7'd0, unit_err}, {7'd0, e[2]});
      chk("tx_pause", {7'd0, tx_pause}, {7'd0, exp_pause});
      rd = {reqq_read, memq_read, netq_read};
      @(posedge clk);
      if (netq_space < 4'd5) exp_pause = 1'b1;
      else if (netq_space >= 4'd8) exp_pause = 1'b0;
      #1;
      if (rd[2] && req_m.size() != 0) void'(req_m.pop_front());
      if (rd[1] && mem_m.size() != 0) void'(mem_m.pop_front());
      if (rd[0] && net_m.size() != 0) void'(net_m.pop_front());
      drive();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      req_m.delete();
      mem_m.delete();
      net_m.delete();
      exp_q.delete();
      net_hold  = 1'b0;
      reqfin    = 1'b1;
      exp_pause = 1'b0;
      drive();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n    = 1'b0;
      reqfin     = 1'b1;
      net_hold   = 1'b0;
      netq_space = 4'd15;
      exp_pause  = 1'b0;
      drive();
      #1;
      chk("rst_sel", {6'd0, sel}, 8'd0);
      chk("rst_reads", {5'd0, reqq_read, memq_read, netq_read}, 8'd0);
      chk("rst_flags", {6'd0, tx_pause, unit_err}, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Idle with all queues empty.
      push(3'b000, 10);
      repeat (10) tick();

      // Pause hysteresis sweep 9 -> 4 -> 6 -> 8.
      push(3'b000, 6);
      netq_space = 4'd9; tick();
      netq_space = 4'd4; tick();
      tick();
      netq_space = 4'd6; tick();
      netq_space = 4'd8; tick();
      tick();
      netq_space = 4'd15;

      // MEM unit of 3, then REQ unit of 2 back to back.
      do_reset();
      mem_m = '{1'b0, 1'b0, 1'b1};
      drive();
      push(3'b000, 1); push(3'b010, 3); push(3'b001, 2); push(3'b000, 1);
      tick(); tick();
      req_m  = '{1'b0, 1'b1};
      reqfin = 1'b0;
      drive();
      repeat (5) tick();

      // reqfin drops at word 2 of a 4-word MEM unit; no preemption.
      do_reset();
      mem_m = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      req_m = '{1'b1};
      drive();
      push(3'b000, 1); push(3'b010, 4); push(3'b001, 1); push(3'b000, 1);
      tick(); tick();
      reqfin = 1'b0;
      drive();
      repeat (5) tick();

      // Starvation: four single-word MEM units, then NET, then MEM resumes.
      do_reset();
      mem_m = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      net_m = '{1'b1};
      drive();
      push(3'b000, 1); push(3'b010, 4); push(3'b011, 1); push(3'b010, 2); push(3'b000, 1);
      repeat (5) tick();
      chk("hp_cnt_sat", {5'd0, dut.hp_cnt}, 8'd4);
      tick();
      chk("hp_cnt_clr", {5'd0, dut.hp_cnt}, 8'd0);
      repeat (3) tick();

      // NET empties mid-unit for 3 cycles: idle fill, state held.
      do_reset();
      net_m = '{1'b0, 1'b0, 1'b0, 1'b1};
      drive();
      push(3'b000, 1); push(3'b011, 2); push(3'b000, 3); push(3'b011, 2); push(3'b000, 1);
      repeat (3) tick();
      net_hold = 1'b1;
      drive();
      repeat (3) tick();
      net_hold = 1'b0;
      drive();
      repeat (3) tick();

      // Watchdog: 20 NET words without a last flag.
      do_reset();
      for (int i = 0; i < 20; i++) net_m.push_back(1'b0);
      drive();
      push(3'b000, 1); push(3'b011, 16); push(3'b111, 1); push(3'b011, 3); push(3'b000, 1);
      repeat (22) tick();

      // Async reset in the middle of a MEM unit, with tx_pause set.
      do_reset();
      netq_space = 4'd4;
      mem_m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      drive();
      push(3'b000, 1); push(3'b010, 2);
      repeat (3) tick();
      #1;
      chk("pre_rst_sel", {6'd0, sel}, 8'h02);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_sel", {6'd0, sel}, 8'd0);
      chk("mid_rst_reads", {5'd0, reqq_read, memq_read, netq_read}, 8'd0);
      chk("mid_rst_flags", {6'd0, tx_pause, unit_err}, 8'd0);
      netq_space = 4'd15;
      do_reset();
      push(3'b000, 2);
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
